// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   DEFAULT_CLKS_PER_BIT : default bit period in clk cycles (100 MHz / 115200)
//   UART_DATA_BITS       : payload bits per frame
//   rx_state_t           : receiver FSM state encoding
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int UART_DATA_BITS       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for a single asynchronous input.
//   clk   in  destination clock
//   rst_n in  async active-low reset, loads RESET_VAL into both flops
//   i_d   in  asynchronous input
//   o_q   out synchronized output
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver, LSB first, fixed baud.
//   clk       in  system clock
//   rst_n     in  async active-low reset
//   rx        in  serial line (async, idles high)
//   data      out received byte, stable while valid
//   valid     out data holds an unconsumed byte
//   ready     in  consumer takes data when valid && ready
//   frame_err out one-cycle pulse: stop bit low, byte discarded
//   overrun   out one-cycle pulse: byte completed while output full, dropped
//
// state | meaning
// IDLE  | waiting for a 1->0 transition on the synchronized line
// START | half a bit period in, confirm the start bit is still low
// DATA  | sample one data bit per bit period, LSB first
// STOP  | sample the stop bit, deliver or discard the byte
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  input  logic                      ready,
  output logic                      frame_err,
  output logic                      overrun
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(UART_DATA_BITS - 1);

  logic                      w_rx_s;
  logic                      r_rx_q;
  rx_state_t                 r_state;
  logic [CW-1:0]             r_cnt;
  logic [2:0]                r_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_data;
  logic                      r_valid;
  logic                      r_frame_err;
  logic                      r_overrun;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (rx),
    .o_q  (w_rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_q      <= 1'b1;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_rx_q      <= w_rx_s;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      // Consumer handshake; a byte completing this same cycle reloads valid below.
      if (r_valid && ready) r_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (r_rx_q && !w_rx_s) begin
            r_state <= START;
            r_cnt   <= '0;
          end
        end
        START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt <= '0;
            if (!w_rx_s) begin
              r_state <= DATA;
              r_idx   <= '0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= w_rx_s;
            r_idx          <= r_idx + 3'd1;
            if (r_idx == IDX_LAST) r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt   <= '0;
            // Back in IDLE at the stop sample so a back-to-back start is caught.
            r_state <= IDLE;
            if (w_rx_s) begin
              if (!r_valid || ready) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  // Event monitor, sampled mid-cycle.
  int         rise_cnt = 0;
  int         rise_cyc = -1;
  logic [7:0] rise_data[$];
  int         fe_cnt   = 0;
  int         ov_cnt   = 0;
  logic       prev_v   = 1'b0;

  always @(negedge clk) begin
    if (valid && !prev_v) begin
      rise_cnt++;
      rise_cyc = cyc;
      rise_data.push_back(data);
    end
    prev_v = valid;
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_v;
    tick(CPB);
    rx = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  int         t0, base, ovb, feb;
  logic       saw_start, bad_state;
  logic [7:0] b99;

  initial begin
    // Reset
    rst_n = 1'b0; rx = 1'b1; ready = 1'b0;
    tick(3);
    check("rst_data",  32'(data),      32'h0);
    check("rst_valid", 32'(valid),     32'h0);
    check("rst_ferr",  32'(frame_err), 32'h0);
    check("rst_ovr",   32'(overrun),   32'h0);
    @(negedge clk) rst_n = 1'b1;
    tick(5);

    // Single frame 0x42, latency and handshake
    t0 = cyc;
    send_frame(8'h42, 1'b1);
    check("t1_rise_cyc", 32'(rise_cyc), 32'(t0 + 79));
    check("t1_data",     32'(data),     32'h42);
    check("t1_valid",    32'(valid),    32'h1);
    ready = 1'b1;
    tick(1);
    check("t1_clear",    32'(valid),    32'h0);
    tick(5);

    // Back-to-back frames with ready held high
    base = rise_cnt; ovb = ov_cnt;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    tick(4);
    check("t2_count", 32'(rise_cnt - base),  32'd2);
    check("t2_byte0", 32'(rise_data[base]),  32'hA5);
    check("t2_byte1", 32'(rise_data[base+1]), 32'h3C);
    check("t2_no_ovr", 32'(ov_cnt - ovb),    32'd0);

    // Overrun
    ready = 1'b0;
    tick(2);
    send_frame(8'h55, 1'b1);
    tick(1);
    check("t3_valid1", 32'(valid), 32'h1);
    check("t3_data1",  32'(data),  32'h55);
    ovb = ov_cnt;
    send_frame(8'h0F, 1'b1);
    tick(2);
    check("t3_ovr",    32'(ov_cnt - ovb), 32'd1);
    check("t3_data2",  32'(data),  32'h55);
    check("t3_valid2", 32'(valid), 32'h1);
    ready = 1'b1;
    tick(1);
    check("t3_drain",  32'(valid), 32'h0);
    ready = 1'b0;
    tick(4);

    // Framing error then recovery
    feb = fe_cnt; base = rise_cnt;
    send_frame(8'hFF, 1'b0);
    tick(3);
    check("t4_ferr",   32'(fe_cnt - feb),    32'd1);
    check("t4_valid0", 32'(valid),           32'h0);
    check("t4_norise", 32'(rise_cnt - base), 32'd0);
    tick(6);
    send_frame(8'h81, 1'b1);
    tick(2);
    check("t4_valid1", 32'(valid), 32'h1);
    check("t4_data",   32'(data),  32'h81);

    // Short glitch in IDLE
    feb = fe_cnt; base = rise_cnt;
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    saw_start = 1'b0; bad_state = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (dut.r_state == START) saw_start = 1'b1;
      if (dut.r_state == DATA || dut.r_state == STOP) bad_state = 1'b1;
    end
    check("t5_saw_start", 32'(saw_start), 32'h1);
    check("t5_no_data",   32'(bad_state), 32'h0);
    check("t5_idle",      32'(dut.r_state), 32'(IDLE));
    check("t5_no_ferr",   32'(fe_cnt - feb),    32'd0);
    check("t5_no_rise",   32'(rise_cnt - base), 32'd0);
    check("t5_held",      32'(data),            32'h81);

    // Reset during data bit 4 of 0x99, then a clean 0x66
    base = rise_cnt;
    b99 = 8'h99;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = b99[i];
      tick(CPB);
    end
    rx = b99[4];
    tick(4);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_data",  32'(data),      32'h0);
    check("t6_rst_valid", 32'(valid),     32'h0);
    check("t6_rst_ferr",  32'(frame_err), 32'h0);
    check("t6_rst_ovr",   32'(overrun),   32'h0);
    check("t6_rst_state", 32'(dut.r_state), 32'(IDLE));
    rx = 1'b1;
    tick(4);
    @(negedge clk) rst_n = 1'b1;
    tick(20);
    send_frame(8'h66, 1'b1);
    tick(3);
    check("t6_count", 32'(rise_cnt - base), 32'd1);
    check("t6_byte",  32'(rise_data[base]), 32'h66);
    check("t6_data",  32'(data),            32'h66);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
